// File: rtl/cpu_regfile_scheduler.sv
// Register-file access scheduler: busy scoreboard, decode/debug read-port arbitration, single writeback port.
// Debug read path is built only when CPU_REGFILE_DEBUG_EN is defined.
module cpu_regfile_scheduler (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_dec_request,
  input  logic [4:0]  i_dec_rs1_idx,
  input  logic [4:0]  i_dec_rs2_idx,
  input  logic [4:0]  i_dec_rd_idx,
  input  logic        i_dec_rd_write,
  output logic        o_dec_ready,
  output logic        o_dec_valid,
  output logic [31:0] o_dec_rs1,
  output logic [31:0] o_dec_rs2,
  input  logic        i_alu_wr_request,
  input  logic [4:0]  i_alu_wr_idx,
  input  logic [31:0] i_alu_wr_data,
  input  logic        i_mem_wr_request,
  input  logic [4:0]  i_mem_wr_idx,
  input  logic [31:0] i_mem_wr_data,
  output logic        o_alu_wr_ready,
  output logic        o_mem_wr_ready,
  input  logic        i_dbg_request,
  input  logic [4:0]  i_dbg_idx,
  output logic        o_dbg_ready,
  output logic        o_dbg_valid,
  output logic [31:0] o_dbg_data,
  output logic        o_read,
  output logic [4:0]  o_read_rs1_idx,
  output logic [4:0]  o_read_rs2_idx,
  output logic        o_wr_request,
  output logic [4:0]  o_wr_idx,
  output logic [31:0] o_rd,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2
);

  logic        run;
  logic [31:0] busy_q, busy_d;
  logic        dec_valid_q, dec_valid_d;
  logic        wr_req_q, wr_req_d;
  logic [4:0]  wr_idx_q, wr_idx_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        dep, dec_ok, dec_grant, dbg_win;
  logic        mem_acc, alu_acc;

  // Every output is forced low during reset, including registered ones still holding pre-reset values.
  assign run = !i_reset;

  assign dep = busy_q[i_dec_rs1_idx] || busy_q[i_dec_rs2_idx] ||
               (i_dec_rd_write && busy_q[i_dec_rd_idx]);
  assign dec_ok    = run && i_dec_request && !dep;
  assign dec_grant = dec_ok && !dbg_win;

`ifdef CPU_REGFILE_DEBUG_EN
  logic [3:0] starve_q, starve_d;
  logic       dbg_valid_q;

  assign dbg_win = run && i_dbg_request && (!dec_ok || starve_q == 4'd8);

  always_comb begin
    starve_d = starve_q;
    if (dbg_win)
      starve_d = '0;
    else if (i_dbg_request && starve_q != 4'd8)
      starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      starve_q    <= '0;
      dbg_valid_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      dbg_valid_q <= dbg_win;
    end
  end

  assign o_dbg_ready = dbg_win;
  assign o_dbg_valid = run && dbg_valid_q;
  assign o_dbg_data  = o_dbg_valid ? i_rs1 : '0;
`else
  logic dbg_unused;
  assign dbg_unused  = i_dbg_request;
  assign dbg_win     = 1'b0;
  assign o_dbg_ready = 1'b0;
  assign o_dbg_valid = 1'b0;
  assign o_dbg_data  = '0;
`endif

  assign o_dec_ready    = dec_grant;
  assign o_read         = dec_grant || dbg_win;
  assign o_read_rs1_idx = dbg_win ? i_dbg_idx : (dec_grant ? i_dec_rs1_idx : '0);
  assign o_read_rs2_idx = dbg_win ? i_dbg_idx : (dec_grant ? i_dec_rs2_idx : '0);

  assign dec_valid_d = dec_grant;
  assign o_dec_valid = run && dec_valid_q;
  assign o_dec_rs1   = o_dec_valid ? i_rs1 : '0;
  assign o_dec_rs2   = o_dec_valid ? i_rs2 : '0;

  // The output stage drains every cycle, so a new write can always be taken alongside it.
  assign o_mem_wr_ready = run;
  assign o_alu_wr_ready = run && !i_mem_wr_request;
  assign mem_acc = run && i_mem_wr_request;
  assign alu_acc = run && i_alu_wr_request && !i_mem_wr_request;

  always_comb begin
    wr_idx_d  = '0;
    wr_data_d = '0;
    if (mem_acc) begin
      wr_idx_d  = i_mem_wr_idx;
      wr_data_d = i_mem_wr_data;
    end else if (alu_acc) begin
      wr_idx_d  = i_alu_wr_idx;
      wr_data_d = i_alu_wr_data;
    end
    wr_req_d = (mem_acc || alu_acc) && (wr_idx_d != 5'd0);
  end

  assign o_wr_request = run && wr_req_q;
  assign o_wr_idx     = o_wr_request ? wr_idx_q : '0;
  assign o_rd         = o_wr_request ? wr_data_q : '0;

  always_comb begin
    busy_d = busy_q;
    if (wr_req_q)
      busy_d[wr_idx_q] = 1'b0;
    if (dec_grant && i_dec_rd_write && i_dec_rd_idx != 5'd0)
      busy_d[i_dec_rd_idx] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      busy_q      <= '0;
      dec_valid_q <= 1'b0;
      wr_req_q    <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      dec_valid_q <= dec_valid_d;
      wr_req_q    <= wr_req_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_cpu_regfile_scheduler.sv
// Bench for cpu_regfile_scheduler: register-file environment, per-cycle reference model, directed scenarios.
module tb_cpu_regfile_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset, i_dec_request, i_dec_rd_write;
  logic [4:0]  i_dec_rs1_idx, i_dec_rs2_idx, i_dec_rd_idx;
  logic        i_alu_wr_request, i_mem_wr_request, i_dbg_request;
  logic [4:0]  i_alu_wr_idx, i_mem_wr_idx, i_dbg_idx;
  logic [31:0] i_alu_wr_data, i_mem_wr_data, i_rs1, i_rs2;
  logic        o_dec_ready, o_dec_valid, o_alu_wr_ready, o_mem_wr_ready;
  logic        o_dbg_ready, o_dbg_valid, o_read, o_wr_request;
  logic [31:0] o_dec_rs1, o_dec_rs2, o_dbg_data, o_rd;
  logic [4:0]  o_read_rs1_idx, o_read_rs2_idx, o_wr_idx;

  cpu_regfile_scheduler dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_dec_request(i_dec_request), .i_dec_rs1_idx(i_dec_rs1_idx), .i_dec_rs2_idx(i_dec_rs2_idx),
    .i_dec_rd_idx(i_dec_rd_idx), .i_dec_rd_write(i_dec_rd_write),
    .o_dec_ready(o_dec_ready), .o_dec_valid(o_dec_valid), .o_dec_rs1(o_dec_rs1), .o_dec_rs2(o_dec_rs2),
    .i_alu_wr_request(i_alu_wr_request), .i_alu_wr_idx(i_alu_wr_idx), .i_alu_wr_data(i_alu_wr_data),
    .i_mem_wr_request(i_mem_wr_request), .i_mem_wr_idx(i_mem_wr_idx), .i_mem_wr_data(i_mem_wr_data),
    .o_alu_wr_ready(o_alu_wr_ready), .o_mem_wr_ready(o_mem_wr_ready),
    .i_dbg_request(i_dbg_request), .i_dbg_idx(i_dbg_idx),
    .o_dbg_ready(o_dbg_ready), .o_dbg_valid(o_dbg_valid), .o_dbg_data(o_dbg_data),
    .o_read(o_read), .o_read_rs1_idx(o_read_rs1_idx), .o_read_rs2_idx(o_read_rs2_idx),
    .o_wr_request(o_wr_request), .o_wr_idx(o_wr_idx), .o_rd(o_rd),
    .i_rs1(i_rs1), .i_rs2(i_rs2)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Power-on contents of the external register file (sp = x2).
  function automatic logic [31:0] init_val(input int i);
    if (i == 2) return 32'h0001_0400;
    return 32'(i) * 32'h0101_0101;
  endfunction

  // External register file: synchronous read, write on o_wr_request.
  bit          rf_w [32];
  logic [31:0] rf_d [32];
  logic [31:0] rs1_q, rs2_q;

  function automatic logic [31:0] rf_val(input logic [4:0] idx);
    return rf_w[idx] ? rf_d[idx] : init_val(int'(idx));
  endfunction

  always @(posedge clk) begin
    if (o_read) begin
      rs1_q <= rf_val(o_read_rs1_idx);
      rs2_q <= rf_val(o_read_rs2_idx);
    end
    if (o_wr_request) begin
      rf_w[o_wr_idx] <= 1'b1;
      rf_d[o_wr_idx] <= o_rd;
    end
  end
  assign i_rs1 = rs1_q;
  assign i_rs2 = rs2_q;

  // Reference model: evaluated mid-cycle from current inputs, committed at the next rising edge.
  initial begin
    logic [31:0] mr [32];
    bit          mb [32];
    int          starve, n_starve;
    bit          m_dv, n_dv, m_gv, n_gv, m_wv, n_wv, rst_seen;
    logic [31:0] m_d1, m_d2, n_d1, n_d2, m_gd, n_gd, m_wd, n_wd;
    logic [4:0]  m_wi, n_wi;
    bit          dep, dec_ok, dec_g, dbg_g, set_rd;
    for (int i = 0; i < 32; i++) begin
      mr[i] = init_val(i);
      mb[i] = 1'b0;
    end
    starve = 0; m_dv = 0; m_gv = 0; m_wv = 0;
    m_d1 = '0; m_d2 = '0; m_gd = '0; m_wd = '0; m_wi = '0;
    forever begin
      @(negedge clk);
      rst_seen = i_reset;
      set_rd = 1'b0; n_dv = 0; n_gv = 0; n_wv = 0; n_starve = 0;
      n_d1 = '0; n_d2 = '0; n_gd = '0; n_wd = '0; n_wi = '0;
      if (i_reset) begin
        chk1("rst_dec_ready", o_dec_ready, 1'b0);
        chk1("rst_dec_valid", o_dec_valid, 1'b0);
        chk("rst_dec_rs1", o_dec_rs1, '0);
        chk("rst_dec_rs2", o_dec_rs2, '0);
        chk1("rst_alu_ready", o_alu_wr_ready, 1'b0);
        chk1("rst_mem_ready", o_mem_wr_ready, 1'b0);
        chk1("rst_dbg_ready", o_dbg_ready, 1'b0);
        chk1("rst_dbg_valid", o_dbg_valid, 1'b0);
        chk("rst_dbg_data", o_dbg_data, '0);
        chk1("rst_read", o_read, 1'b0);
        chk({27'b0, o_read_rs1_idx} == 0 && o_read_rs2_idx == 0 ? "rst_ridx" : "rst_ridx",
            {22'b0, o_read_rs1_idx, o_read_rs2_idx}, '0);
        chk1("rst_wr_req", o_wr_request, 1'b0);
        chk("rst_wr_idx", {27'b0, o_wr_idx}, '0);
        chk("rst_rd", o_rd, '0);
      end else begin
        dep = i_dec_request && (mb[i_dec_rs1_idx] || mb[i_dec_rs2_idx] ||
                                (i_dec_rd_write && mb[i_dec_rd_idx]));
        dec_ok = i_dec_request && !dep;
        dbg_g = 1'b0;
`ifdef CPU_REGFILE_DEBUG_EN
        dbg_g = i_dbg_request && (!dec_ok || starve == 8);
`endif
        dec_g = dec_ok && !dbg_g;
        chk1("m_dec_ready", o_dec_ready, dec_g);
        chk1("m_dbg_ready", o_dbg_ready, dbg_g);
        chk1("m_read", o_read, dec_g || dbg_g);
        if (dbg_g) begin
          chk("m_ridx1_dbg", {27'b0, o_read_rs1_idx}, {27'b0, i_dbg_idx});
          chk("m_ridx2_dbg", {27'b0, o_read_rs2_idx}, {27'b0, i_dbg_idx});
        end else if (dec_g) begin
          chk("m_ridx1", {27'b0, o_read_rs1_idx}, {27'b0, i_dec_rs1_idx});
          chk("m_ridx2", {27'b0, o_read_rs2_idx}, {27'b0, i_dec_rs2_idx});
        end
        chk1("m_dec_valid", o_dec_valid, m_dv);
        if (m_dv) begin
          chk("m_dec_rs1", o_dec_rs1, m_d1);
          chk("m_dec_rs2", o_dec_rs2, m_d2);
        end
        chk1("m_dbg_valid", o_dbg_valid, m_gv);
        if (m_gv) chk("m_dbg_data", o_dbg_data, m_gd);
`ifndef CPU_REGFILE_DEBUG_EN
        chk("m_dbg_data_tied", o_dbg_data, '0);
`endif
        chk1("m_mem_ready", o_mem_wr_ready, 1'b1);
        chk1("m_alu_ready", o_alu_wr_ready, !i_mem_wr_request);
        chk1("m_wr_req", o_wr_request, m_wv);
        if (m_wv) begin
          chk("m_wr_idx", {27'b0, o_wr_idx}, {27'b0, m_wi});
          chk("m_wr_data", o_rd, m_wd);
        end
        n_dv = dec_g; n_d1 = mr[i_dec_rs1_idx]; n_d2 = mr[i_dec_rs2_idx];
        n_gv = dbg_g; n_gd = mr[i_dbg_idx];
        if (dbg_g) n_starve = 0;
        else if (i_dbg_request) n_starve = (starve < 8) ? starve + 1 : 8;
        else n_starve = starve;
        set_rd = dec_g && i_dec_rd_write && i_dec_rd_idx != 0;
        if (i_mem_wr_request) begin
          n_wv = i_mem_wr_idx != 0; n_wi = i_mem_wr_idx; n_wd = i_mem_wr_data;
        end else if (i_alu_wr_request) begin
          n_wv = i_alu_wr_idx != 0; n_wi = i_alu_wr_idx; n_wd = i_alu_wr_data;
        end
      end
      @(posedge clk);
      if (rst_seen) begin
        for (int i = 0; i < 32; i++) mb[i] = 1'b0;
        starve = 0; m_dv = 0; m_gv = 0; m_wv = 0;
      end else begin
        if (m_wv) begin
          mb[m_wi] = 1'b0;
          mr[m_wi] = m_wd;
        end
        if (set_rd) mb[i_dec_rd_idx] = 1'b1;
        starve = n_starve;
        m_dv = n_dv; m_d1 = n_d1; m_d2 = n_d2;
        m_gv = n_gv; m_gd = n_gd;
        m_wv = n_wv; m_wi = n_wi; m_wd = n_wd;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic req, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input logic w);
    i_dec_request = req; i_dec_rs1_idx = r1; i_dec_rs2_idx = r2; i_dec_rd_idx = rd; i_dec_rd_write = w;
  endtask

  task automatic alu(input logic req, input logic [4:0] idx, input logic [31:0] d);
    i_alu_wr_request = req; i_alu_wr_idx = idx; i_alu_wr_data = d;
  endtask

  task automatic mem(input logic req, input logic [4:0] idx, input logic [31:0] d);
    i_mem_wr_request = req; i_mem_wr_idx = idx; i_mem_wr_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1'b1;
    dec(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
    alu(1'b0, '0, '0);
    mem(1'b0, '0, '0);
    i_dbg_request = 1'b0; i_dbg_idx = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("reset_dec_ready", o_dec_ready, 1'b0);
      chk1("reset_read", o_read, 1'b0);
      step();
    end
    i_reset = 1'b0;

    // Issue writing x5, then a consumer of x5 that must wait for the writeback.
    @(negedge clk); chk1("raw_issue", o_dec_ready, 1'b1);
    step(); dec(1'b1, 5'd5, 5'd0, 5'd6, 1'b1);
    @(negedge clk);
    chk1("raw_stall0", o_dec_ready, 1'b0);
    chk1("raw_dvalid", o_dec_valid, 1'b1);
    chk("raw_rs1", o_dec_rs1, 32'h0101_0101);
    chk("raw_rs2", o_dec_rs2, 32'h0001_0400);
    step(); alu(1'b1, 5'd5, 32'hCAFE_0005);
    @(negedge clk); chk1("raw_stall1", o_dec_ready, 1'b0); chk1("raw_alu_ready", o_alu_wr_ready, 1'b1);
    step(); alu(1'b0, '0, '0);
    @(negedge clk);
    chk1("raw_wr_req", o_wr_request, 1'b1);
    chk("raw_wr_idx", {27'b0, o_wr_idx}, 32'd5);
    chk1("raw_stall2", o_dec_ready, 1'b0);
    step();
    @(negedge clk); chk1("raw_release", o_dec_ready, 1'b1);
    step(); dec(1'b1, 5'd6, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("raw_fwd_rs1", o_dec_rs1, 32'hCAFE_0005);
    chk1("busy6_stall", o_dec_ready, 1'b0);
    step(); dec(1'b0, '0, '0, '0, 1'b0);

    // Simultaneous mem/alu writes: mem first, alu the following cycle.
    mem(1'b1, 5'd4, 32'h22); alu(1'b1, 5'd3, 32'h11);
    @(negedge clk); chk1("arb_mem_ready", o_mem_wr_ready, 1'b1); chk1("arb_alu_ready", o_alu_wr_ready, 1'b0);
    step(); mem(1'b0, '0, '0);
    @(negedge clk);
    chk1("arb_alu_ready2", o_alu_wr_ready, 1'b1);
    chk("arb_w1_idx", {27'b0, o_wr_idx}, 32'd4);
    chk("arb_w1_data", o_rd, 32'h22);
    step(); alu(1'b0, '0, '0);
    @(negedge clk);
    chk("arb_w2_idx", {27'b0, o_wr_idx}, 32'd3);
    chk("arb_w2_data", o_rd, 32'h11);
    step();

    // Back-to-back ALU writes sustain one per cycle.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) alu(1'b1, 5'(8 + k), 32'h80 + 32'(k));
      else alu(1'b0, '0, '0);
      @(negedge clk);
      if (k < 3) chk1("b2b_ready", o_alu_wr_ready, 1'b1);
      if (k > 0) begin
        chk1("b2b_wr_req", o_wr_request, 1'b1);
        chk("b2b_wr_idx", {27'b0, o_wr_idx}, 32'(7 + k));
      end
      step();
    end

    // Write to x0 is accepted and discarded.
    alu(1'b1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk); chk1("x0_ready", o_alu_wr_ready, 1'b1);
    step(); alu(1'b0, '0, '0);
    @(negedge clk); chk1("x0_no_write", o_wr_request, 1'b0);
    step();

    // Reset right after an accepted write and a granted issue drops both.
    alu(1'b1, 5'd7, 32'h77); dec(1'b1, 5'd1, 5'd1, 5'd0, 1'b0);
    @(negedge clk); chk1("mid_accept", o_alu_wr_ready, 1'b1);
    step(); alu(1'b0, '0, '0); dec(1'b0, '0, '0, '0, 1'b0); i_reset = 1'b1;
    @(negedge clk);
    chk1("mid_wr_req", o_wr_request, 1'b0);
    chk("mid_wr_idx", {27'b0, o_wr_idx}, '0);
    chk("mid_rd", o_rd, '0);
    chk1("mid_dvalid", o_dec_valid, 1'b0);
    step(); i_reset = 1'b0; dec(1'b1, 5'd6, 5'd7, 5'd6, 1'b1);
    @(negedge clk);
    chk1("post_wr_req", o_wr_request, 1'b0);
    chk1("post_dvalid", o_dec_valid, 1'b0);
    chk1("post_sb_clear", o_dec_ready, 1'b1);
    step(); dec(1'b0, '0, '0, '0, 1'b0);
    step();

`ifdef CPU_REGFILE_DEBUG_EN
    // Continuous decode starves debug for 8 cycles; debug wins the 9th.
    dec(1'b1, 5'd1, 5'd1, 5'd0, 1'b0); i_dbg_request = 1'b1; i_dbg_idx = 5'd2;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk1("starve_dbg_ready", o_dbg_ready, k == 9);
      chk1("starve_dec_ready", o_dec_ready, k != 9);
      if (k == 9) chk("starve_ridx", {27'b0, o_read_rs1_idx}, 32'd2);
      step();
    end
    i_dbg_request = 1'b0;
    @(negedge clk);
    chk1("sp_valid", o_dbg_valid, 1'b1);
    chk("sp_data", o_dbg_data, 32'h0001_0400);
    step(); dec(1'b0, '0, '0, '0, 1'b0); i_dbg_request = 1'b1; i_dbg_idx = 5'd3;
    @(negedge clk); chk1("idle_dbg_ready", o_dbg_ready, 1'b1);
    step(); i_dbg_request = 1'b0;
    @(negedge clk); chk("idle_dbg_data", o_dbg_data, 32'h11);
    step();
`else
    // Debug path absent: requests are ignored and decode keeps the port.
    dec(1'b1, 5'd1, 5'd1, 5'd0, 1'b0); i_dbg_request = 1'b1; i_dbg_idx = 5'd2;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk1("nodbg_ready", o_dbg_ready, 1'b0);
      chk1("nodbg_valid", o_dbg_valid, 1'b0);
      chk1("nodbg_dec", o_dec_ready, 1'b1);
      step();
    end
    i_dbg_request = 1'b0; dec(1'b0, '0, '0, '0, 1'b0);
`endif
    step();
    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cpu_regfile_scheduler.md
CPU_REGFILE_SCHEDULER -- requirements
Module: cpu_regfile_scheduler

Interface
REQ-001 SHALL have port i_clock, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have decode inputs i_dec_request (1), i_dec_rs1_idx (5), i_dec_rs2_idx (5), i_dec_rd_idx (5), i_dec_rd_write (1, instruction writes rd).
REQ-004 SHALL have decode outputs o_dec_ready (1, issue granted this cycle), o_dec_valid (1), o_dec_rs1 (32), o_dec_rs2 (32).
REQ-005 SHALL have writeback inputs i_alu_wr_request (1), i_alu_wr_idx (5), i_alu_wr_data (32), i_mem_wr_request (1), i_mem_wr_idx (5), i_mem_wr_data (32); outputs o_alu_wr_ready (1), o_mem_wr_ready (1).
REQ-006 SHALL have debug ports i_dbg_request (1), i_dbg_idx (5), outputs o_dbg_ready (1), o_dbg_valid (1), o_dbg_data (32).
REQ-007 SHALL have register-file side outputs o_read (1), o_read_rs1_idx (5), o_read_rs2_idx (5), o_wr_request (1), o_wr_idx (5), o_rd (32); inputs i_rs1 (32), i_rs2 (32).

Function
REQ-008 SHALL keep a 32-bit busy scoreboard; bit 0 permanently 0.
REQ-009 SHALL stall decode (o_dec_ready=0) while i_dec_request and busy[rs1], busy[rs2] or (i_dec_rd_write and busy[rd]).
REQ-010 SHALL set busy[rd] at the edge ending a granted issue with i_dec_rd_write=1 and rd!=0.
REQ-011 SHALL arbitrate the single read port per cycle: unstalled decode wins over debug, except when the debug starvation counter equals 8.
REQ-012 SHALL increment a 4-bit starvation counter each cycle debug requests and loses, saturating at 8; cleared on debug grant.
REQ-013 SHALL drive o_read=1 combinationally in the grant cycle with indices of the winner (debug drives i_dbg_idx on both index outputs).
REQ-014 SHALL assert o_dec_valid or o_dbg_valid exactly one cycle after the respective grant, passing i_rs1/i_rs2 through as o_dec_rs1/o_dec_rs2, or i_rs1 as o_dbg_data.
REQ-015 SHALL accept at most one writeback per cycle; mem wins over alu when both request; ready outputs combinational.
REQ-016 SHALL register an accepted write: o_wr_request, o_wr_idx, o_rd valid the following cycle for exactly one cycle.
REQ-017 SHALL clear busy[o_wr_idx] at the edge ending the cycle in which o_wr_request=1; dependent issue earliest the next cycle.
REQ-018 SHALL accept writes to index 0 without asserting o_wr_request and without scoreboard change.
REQ-019 SHALL deassert both write readys while a registered write is outstanding only if a new accept and an output cycle would collide; back-to-back accepts SHALL otherwise sustain one write per cycle.

Reset
REQ-020 SHALL, while i_reset=1, clear scoreboard and starvation counter, drive all ready/valid/request outputs 0, index and data outputs 0.
REQ-021 SHALL drop any accepted-but-unwritten write and suppress any pending valid when reset asserts mid-operation.

Configuration
REQ-022 SHALL gate the debug read path with macro CPU_REGFILE_DEBUG_EN.
REQ-023 With CPU_REGFILE_DEBUG_EN defined, debug behaves per REQ-011..014.
REQ-024 Without CPU_REGFILE_DEBUG_EN, debug ports SHALL remain present, o_dbg_ready/o_dbg_valid/o_dbg_data tied 0, starvation counter absent, decode always wins.

Verification
REQ-025 Issue rd=5 write, then rs1=5 next cycle -> second stalls until cycle after o_wr_request with o_wr_idx=5; then o_dec_ready=1.
REQ-026 ALU idx 3 data 0x11 and mem idx 4 data 0x22 same cycle -> o_mem_wr_ready=1, o_alu_wr_ready=0; writes appear 4/0x22 then 3/0x11 on consecutive cycles.
REQ-027 Continuous decode requests plus debug idx 2 (sp) -> debug granted on 9th cycle, o_dbg_valid next cycle with o_dbg_data=0x00010400 after reset.
REQ-028 ALU write idx 0 data 0xFFFFFFFF -> o_alu_wr_ready=1, o_wr_request stays 0.
REQ-029 Reset asserted cycle after write accept -> o_wr_request never asserts, scoreboard all 0, all outputs 0.
REQ-030 Build without CPU_REGFILE_DEBUG_EN, hold i_dbg_request=1 for 20 cycles -> o_dbg_ready and o_dbg_valid stay 0.
